// File: rtl/vx_tl_mem_adapter_if.sv
// Pipeline cache request/response buses and TileLink A/D channels bundled for vx_tl_mem_adapter.
// Vectors are lane-packed with lane 0 in the LSBs.
interface vx_tl_mem_adapter_if #(
   parameter int NUM_LANES = 4,
   parameter int ITAG_W    = 8,
   parameter int DTAG_W    = 8,
   parameter int SRC_W     = 10
);
   logic                     icache_req_valid;
   logic [29:0]              icache_req_addr;
   logic [ITAG_W-1:0]        icache_req_tag;
   logic                     icache_req_ready;

   logic                     icache_rsp_valid;
   logic [31:0]              icache_rsp_data;
   logic [ITAG_W-1:0]        icache_rsp_tag;
   logic                     icache_rsp_ready;

   logic [NUM_LANES-1:0]     dcache_req_valid;
   logic [NUM_LANES-1:0]     dcache_req_rw;
   logic [4*NUM_LANES-1:0]   dcache_req_byteen;
   logic [30*NUM_LANES-1:0]  dcache_req_addr;
   logic [32*NUM_LANES-1:0]  dcache_req_data;
   logic [DTAG_W-1:0]        dcache_req_tag;
   logic [NUM_LANES-1:0]     dcache_req_ready;

   logic                     dcache_rsp_valid;
   logic [NUM_LANES-1:0]     dcache_rsp_tmask;
   logic [32*NUM_LANES-1:0]  dcache_rsp_data;
   logic [DTAG_W-1:0]        dcache_rsp_tag;
   logic                     dcache_rsp_ready;

   logic                     imem_a_valid;
   logic [2:0]               imem_a_opcode;
   logic [3:0]               imem_a_size;
   logic [SRC_W-1:0]         imem_a_source;
   logic [31:0]              imem_a_address;
   logic [3:0]               imem_a_mask;
   logic [31:0]              imem_a_data;
   logic                     imem_a_ready;

   logic                     imem_d_valid;
   logic [2:0]               imem_d_opcode;
   logic [3:0]               imem_d_size;
   logic [SRC_W-1:0]         imem_d_source;
   logic [31:0]              imem_d_data;
   logic                     imem_d_ready;

   logic [NUM_LANES-1:0]       dmem_a_valid;
   logic [3*NUM_LANES-1:0]     dmem_a_opcode;
   logic [4*NUM_LANES-1:0]     dmem_a_size;
   logic [SRC_W*NUM_LANES-1:0] dmem_a_source;
   logic [32*NUM_LANES-1:0]    dmem_a_address;
   logic [4*NUM_LANES-1:0]     dmem_a_mask;
   logic [32*NUM_LANES-1:0]    dmem_a_data;
   logic [NUM_LANES-1:0]       dmem_a_ready;

   logic [NUM_LANES-1:0]       dmem_d_valid;
   logic [3*NUM_LANES-1:0]     dmem_d_opcode;
   logic [4*NUM_LANES-1:0]     dmem_d_size;
   logic [SRC_W*NUM_LANES-1:0] dmem_d_source;
   logic [32*NUM_LANES-1:0]    dmem_d_data;
   logic [NUM_LANES-1:0]       dmem_d_ready;

   modport slave (
      input  icache_req_valid, icache_req_addr, icache_req_tag,
      output icache_req_ready,
      output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
      input  icache_rsp_ready,
      input  dcache_req_valid, dcache_req_rw, dcache_req_byteen, dcache_req_addr,
      input  dcache_req_data, dcache_req_tag,
      output dcache_req_ready,
      output dcache_rsp_valid, dcache_rsp_tmask, dcache_rsp_data, dcache_rsp_tag,
      input  dcache_rsp_ready,
      output imem_a_valid, imem_a_opcode, imem_a_size, imem_a_source, imem_a_address,
      output imem_a_mask, imem_a_data,
      input  imem_a_ready,
      input  imem_d_valid, imem_d_opcode, imem_d_size, imem_d_source, imem_d_data,
      output imem_d_ready,
      output dmem_a_valid, dmem_a_opcode, dmem_a_size, dmem_a_source, dmem_a_address,
      output dmem_a_mask, dmem_a_data,
      input  dmem_a_ready,
      input  dmem_d_valid, dmem_d_opcode, dmem_d_size, dmem_d_source, dmem_d_data,
      output dmem_d_ready
   );

   modport master (
      output icache_req_valid, icache_req_addr, icache_req_tag,
      input  icache_req_ready,
      input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
      output icache_rsp_ready,
      output dcache_req_valid, dcache_req_rw, dcache_req_byteen, dcache_req_addr,
      output dcache_req_data, dcache_req_tag,
      input  dcache_req_ready,
      input  dcache_rsp_valid, dcache_rsp_tmask, dcache_rsp_data, dcache_rsp_tag,
      output dcache_rsp_ready,
      input  imem_a_valid, imem_a_opcode, imem_a_size, imem_a_source, imem_a_address,
      input  imem_a_mask, imem_a_data,
      output imem_a_ready,
      output imem_d_valid, imem_d_opcode, imem_d_size, imem_d_source, imem_d_data,
      input  imem_d_ready,
      input  dmem_a_valid, dmem_a_opcode, dmem_a_size, dmem_a_source, dmem_a_address,
      input  dmem_a_mask, dmem_a_data,
      output dmem_a_ready,
      output dmem_d_valid, dmem_d_opcode, dmem_d_size, dmem_d_source, dmem_d_data,
      input  dmem_d_ready
   );
endinterface

// File: rtl/vx_tl_mem_adapter.sv
// Combinational bridge from the Vortex icache/dcache ports to TileLink A/D channels,
// plus the msip-triggered core reset pulse and tile status outputs.
module vx_tl_mem_adapter #(
   parameter int NUM_LANES = 4,
   parameter int ITAG_W    = 8,
   parameter int DTAG_W    = 8,
   parameter int SRC_W     = 10,
   parameter int RST_PULSE = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               interrupts_msip,
   output logic               core_reset,
   input  logic               busy,
   output logic               cease,
   output logic               wfi,
   vx_tl_mem_adapter_if.slave bus
);
   localparam int              CNT_W         = $clog2(RST_PULSE + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD      = CNT_W'(RST_PULSE);
   localparam logic [2:0]       TL_GET        = 3'd4;
   localparam logic [2:0]       TL_PUT_FULL   = 3'd0;
   localparam logic [2:0]       TL_ACCESS_ACK = 3'd0;
   localparam logic [3:0]       TL_SIZE_WORD  = 4'd2;

   logic                 r_msip_d;
   logic [CNT_W-1:0]     r_cnt;
   logic [SRC_W-1:0]     w_isrc;
   logic [SRC_W-1:0]     w_dsrc;
   logic [NUM_LANES-1:0] w_lv;
   logic [DTAG_W-1:0]    w_dtag;
   logic                 w_unused_bits;

   // msip edge detector and reset-pulse countdown
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_msip_d <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_msip_d <= interrupts_msip;
         if (!r_msip_d && interrupts_msip) begin
            r_cnt <= CNT_LOAD;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign core_reset = reset | (r_cnt != '0);
   assign cease      = ~busy;
   assign wfi        = 1'b0;

   // Core tags are zero-extended into the wider TileLink source field
   always_comb begin
      w_isrc                 = '0;
      w_isrc[ITAG_W-1:0]     = bus.icache_req_tag;
      w_dsrc                 = '0;
      w_dsrc[DTAG_W-1:0]     = bus.dcache_req_tag;
   end

   assign bus.imem_a_valid     = bus.icache_req_valid;
   assign bus.imem_a_opcode    = TL_GET;
   assign bus.imem_a_size      = TL_SIZE_WORD;
   assign bus.imem_a_source    = w_isrc;
   assign bus.imem_a_address   = {bus.icache_req_addr, 2'b00};
   assign bus.imem_a_mask      = 4'hF;
   assign bus.imem_a_data      = 32'h0000_0000;
   assign bus.icache_req_ready = bus.imem_a_ready;

   assign bus.icache_rsp_valid = bus.imem_d_valid;
   assign bus.icache_rsp_data  = bus.imem_d_data;
   assign bus.icache_rsp_tag   = bus.imem_d_source[ITAG_W-1:0];
   assign bus.imem_d_ready     = bus.icache_rsp_ready;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign bus.dmem_a_valid[g]                 = bus.dcache_req_valid[g];
      assign bus.dmem_a_opcode[g*3 +: 3]         = bus.dcache_req_rw[g] ? TL_PUT_FULL : TL_GET;
      assign bus.dmem_a_size[g*4 +: 4]           = TL_SIZE_WORD;
      assign bus.dmem_a_source[g*SRC_W +: SRC_W] = w_dsrc;
      assign bus.dmem_a_address[g*32 +: 32]      = {bus.dcache_req_addr[g*30 +: 30], 2'b00};
      assign bus.dmem_a_mask[g*4 +: 4]           = bus.dcache_req_byteen[g*4 +: 4];
      assign bus.dmem_a_data[g*32 +: 32]         = bus.dcache_req_data[g*32 +: 32];
      assign bus.dcache_req_ready[g]             = bus.dmem_a_ready[g];

      // Write acks carry no payload for the core; they are consumed but not forwarded
      assign w_lv[g] = bus.dmem_d_valid[g] && (bus.dmem_d_opcode[g*3 +: 3] != TL_ACCESS_ACK);
   end

   // Tag follows the highest-index lane with d_valid, acks included
   always_comb begin
      w_dtag = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_dtag = bus.dmem_d_valid[i] ? bus.dmem_d_source[i*SRC_W +: DTAG_W] : w_dtag;
      end
   end

   assign bus.dcache_rsp_valid = |w_lv;
   assign bus.dcache_rsp_tmask = w_lv;
   assign bus.dcache_rsp_data  = bus.dmem_d_data;
   assign bus.dcache_rsp_tag   = w_dtag;
   assign bus.dmem_d_ready     = {NUM_LANES{bus.dcache_rsp_ready}};

   assign w_unused_bits = ^{bus.imem_d_opcode, bus.imem_d_size, bus.imem_d_source,
                            bus.dmem_d_size, bus.dmem_d_source};
endmodule

// File: tb/tb_vx_tl_mem_adapter.sv
// Randomized bench for vx_tl_mem_adapter: an abstract model checks every output each cycle,
// and directed literal cases pin the channel mapping and reset-pulse timing.
module tb_vx_tl_mem_adapter;
   localparam int N   = 4;
   localparam int ITW = 8;
   localparam int DTW = 8;
   localparam int SW  = 10;
   localparam int RP  = 6;

   logic clock = 1'b0;
   logic reset;
   logic msip;
   logic busy;
   logic core_reset;
   logic cease;
   logic wfi;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   vx_tl_mem_adapter_if #(.NUM_LANES(N), .ITAG_W(ITW), .DTAG_W(DTW), .SRC_W(SW)) bus ();

   vx_tl_mem_adapter #(.NUM_LANES(N), .ITAG_W(ITW), .DTAG_W(DTW), .SRC_W(SW), .RST_PULSE(RP)) dut (
      .clock           (clock),
      .reset           (reset),
      .interrupts_msip (msip),
      .core_reset      (core_reset),
      .busy            (busy),
      .cease           (cease),
      .wfi             (wfi),
      .bus             (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reset-pulse model: remember the clock edge at which the last rising msip was seen
   bit m_prev    = 1'b0;
   bit m_seen    = 1'b0;
   int m_edges   = 0;
   int m_edge_at = 0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_prev <= 1'b0;
         m_seen <= 1'b0;
      end else begin
         m_edges <= m_edges + 1;
         m_prev  <= msip;
         if (!m_prev && msip) begin
            m_seen    <= 1'b1;
            m_edge_at <= m_edges + 1;
         end
      end
   end

   // Every-cycle comparison of all outputs against values derived from the current inputs
   always @(negedge clock) begin
      logic [3*N-1:0]  e_op;
      logic [4*N-1:0]  e_size;
      logic [SW*N-1:0] e_src;
      logic [32*N-1:0] e_addr;
      logic [N-1:0]    e_lv;
      logic [DTW-1:0]  e_tag;
      int              hi;
      if (chk_en) begin
         e_op = '0; e_size = '0; e_src = '0; e_addr = '0; e_lv = '0; e_tag = '0; hi = -1;
         for (int i = 0; i < N; i++) begin
            e_op[i*3 +: 3]    = bus.dcache_req_rw[i] ? 3'd0 : 3'd4;
            e_size[i*4 +: 4]  = 4'd2;
            e_src[i*SW +: SW] = SW'(bus.dcache_req_tag);
            e_addr[i*32 +: 32] = 32'(bus.dcache_req_addr[i*30 +: 30]) * 32'd4;
            e_lv[i] = bus.dmem_d_valid[i] && (bus.dmem_d_opcode[i*3 +: 3] != 3'd0);
         end
         for (int i = N - 1; i >= 0; i--) begin
            if (hi < 0 && bus.dmem_d_valid[i]) hi = i;
         end
         if (hi >= 0) e_tag = bus.dmem_d_source[hi*SW +: DTW];

         check("core_reset", core_reset, reset || (m_seen && (m_edges - m_edge_at) < RP));
         check("cease", cease, !busy);
         check("wfi", wfi, 1'b0);
         check("imem_a_valid", bus.imem_a_valid, bus.icache_req_valid);
         check("imem_a_opcode", bus.imem_a_opcode, 3'd4);
         check("imem_a_size", bus.imem_a_size, 4'd2);
         check("imem_a_source", bus.imem_a_source, SW'(bus.icache_req_tag));
         check("imem_a_address", bus.imem_a_address, 32'(bus.icache_req_addr) * 32'd4);
         check("imem_a_mask", bus.imem_a_mask, 4'hF);
         check("imem_a_data", bus.imem_a_data, 32'd0);
         check("icache_req_ready", bus.icache_req_ready, bus.imem_a_ready);
         check("icache_rsp_valid", bus.icache_rsp_valid, bus.imem_d_valid);
         check("icache_rsp_data", bus.icache_rsp_data, bus.imem_d_data);
         check("icache_rsp_tag", bus.icache_rsp_tag, bus.imem_d_source % (1 << ITW));
         check("imem_d_ready", bus.imem_d_ready, bus.icache_rsp_ready);
         check("dmem_a_valid", bus.dmem_a_valid, bus.dcache_req_valid);
         check("dmem_a_opcode", bus.dmem_a_opcode, e_op);
         check("dmem_a_size", bus.dmem_a_size, e_size);
         check("dmem_a_source", bus.dmem_a_source, e_src);
         check("dmem_a_address", bus.dmem_a_address, e_addr);
         check("dmem_a_mask", bus.dmem_a_mask, bus.dcache_req_byteen);
         check("dmem_a_data", bus.dmem_a_data, bus.dcache_req_data);
         check("dcache_req_ready", bus.dcache_req_ready, bus.dmem_a_ready);
         check("dcache_rsp_valid", bus.dcache_rsp_valid, e_lv != '0);
         check("dcache_rsp_tmask", bus.dcache_rsp_tmask, e_lv);
         check("dcache_rsp_data", bus.dcache_rsp_data, bus.dmem_d_data);
         check("dcache_rsp_tag", bus.dcache_rsp_tag, e_tag);
         check("dmem_d_ready", bus.dmem_d_ready, bus.dcache_rsp_ready ? {N{1'b1}} : {N{1'b0}});
      end
   end

   // Simulation trace of stores into the 0xC000_0000 region
   always @(posedge clock) begin
      for (int i = 0; i < N; i++) begin
         if (bus.dcache_req_valid[i] && bus.dcache_req_ready[i] && bus.dcache_req_rw[i]
             && bus.dcache_req_addr[i*30 + 26 +: 4] == 4'hC) begin
            $display("store lane %0d addr %h data %h", i,
                     {bus.dcache_req_addr[i*30 +: 30], 2'b00}, bus.dcache_req_data[i*32 +: 32]);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.icache_req_valid = 1'b0; bus.icache_req_addr = '0; bus.icache_req_tag = '0;
      bus.icache_rsp_ready = 1'b0;
      bus.dcache_req_valid = '0; bus.dcache_req_rw = '0; bus.dcache_req_byteen = '0;
      bus.dcache_req_addr = '0; bus.dcache_req_data = '0; bus.dcache_req_tag = '0;
      bus.dcache_rsp_ready = 1'b0;
      bus.imem_a_ready = 1'b0;
      bus.imem_d_valid = 1'b0; bus.imem_d_opcode = '0; bus.imem_d_size = '0;
      bus.imem_d_source = '0; bus.imem_d_data = '0;
      bus.dmem_a_ready = '0;
      bus.dmem_d_valid = '0; bus.dmem_d_opcode = '0; bus.dmem_d_size = '0;
      bus.dmem_d_source = '0; bus.dmem_d_data = '0;
   endtask

   task automatic pulse_run(input int drop_at, output int hi_cnt, output int first_hi);
      hi_cnt = 0;
      first_hi = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         msip = (i == drop_at) ? 1'b0 : 1'b1;
         @(negedge clock);
         if (core_reset) begin
            hi_cnt++;
            if (first_hi < 0) first_hi = i;
         end
      end
   endtask

   initial begin
      int          hc;
      int          fh;
      logic [29:0] a;
      clear_inputs();
      reset = 1'b1; msip = 1'b0; busy = 1'b0; chk_en = 1'b1;
      #3;
      check("lit_reset_core_reset", core_reset, 1'b1);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check("lit_idle_core_reset", core_reset, 1'b0);
      check("lit_idle_opcode", bus.imem_a_opcode, 3'd4);
      check("lit_idle_size", bus.imem_a_size, 4'd2);
      check("lit_idle_mask", bus.imem_a_mask, 4'hF);
      check("lit_idle_data", bus.imem_a_data, 32'h0);
      check("lit_idle_wfi", wfi, 1'b0);
      check("lit_idle_cease", cease, 1'b1);

      step();
      bus.icache_req_valid = 1'b1; bus.icache_req_addr = 30'h0000_0400; bus.icache_req_tag = 8'h15;
      #1;
      check("lit_imem_address", bus.imem_a_address, 32'h0000_1000);
      check("lit_imem_source", bus.imem_a_source, 10'h015);
      check("lit_ireq_ready_lo", bus.icache_req_ready, 1'b0);
      bus.imem_a_ready = 1'b1;
      #1;
      check("lit_ireq_ready_hi", bus.icache_req_ready, 1'b1);
      bus.imem_d_valid = 1'b1; bus.imem_d_source = 10'h015; bus.imem_d_data = 32'hDEADBEEF;
      bus.icache_rsp_ready = 1'b1;
      #1;
      check("lit_irsp_tag", bus.icache_rsp_tag, 8'h15);
      check("lit_irsp_data", bus.icache_rsp_data, 32'hDEADBEEF);

      step();
      clear_inputs();
      bus.dcache_req_valid = 4'b0101; bus.dcache_req_rw = 4'b0101;
      bus.dcache_req_byteen = 16'h030F; bus.dcache_req_tag = 8'h07;
      #1;
      check("lit_dmem_a_valid", bus.dmem_a_valid, 4'b0101);
      check("lit_dmem_op_l0", bus.dmem_a_opcode[2:0], 3'd0);
      check("lit_dmem_op_l2", bus.dmem_a_opcode[8:6], 3'd0);
      check("lit_dmem_mask_l2", bus.dmem_a_mask[11:8], 4'h3);
      check("lit_dmem_source", bus.dmem_a_source, {4{10'h007}});
      bus.dmem_d_valid = 4'b1010; bus.dmem_d_opcode = 12'h008;
      bus.dmem_d_source = {10'h00A, 10'h000, 10'h009, 10'h000};
      #1;
      check("lit_tmask", bus.dcache_rsp_tmask, 4'b0010);
      check("lit_rsp_valid", bus.dcache_rsp_valid, 1'b1);
      check("lit_rsp_tag", bus.dcache_rsp_tag, 8'h0A);
      check("lit_d_ready_lo", bus.dmem_d_ready, 4'b0000);
      bus.dcache_rsp_ready = 1'b1;
      #1;
      check("lit_d_ready_hi", bus.dmem_d_ready, 4'b1111);

      step();
      clear_inputs();
      pulse_run(-1, hc, fh);
      check("lit_pulse_len", 32'(hc), 32'd6);
      check("lit_pulse_start", 32'(fh), 32'd1);
      msip = 1'b0;
      repeat (10) step();
      pulse_run(2, hc, fh);
      check("lit_pulse_extended_len", 32'(hc), 32'd9);
      msip = 1'b0;
      repeat (10) step();

      msip = 1'b1;
      step();
      step();
      check("lit_pulse_before_rst", core_reset, 1'b1);
      reset = 1'b1; msip = 1'b0;
      #1;
      check("lit_rst_mid_pulse", core_reset, 1'b1);
      reset = 1'b0;
      #1;
      check("lit_cnt_cleared", core_reset, 1'b0);
      repeat (3) begin
         step();
         check("lit_after_rst_idle", core_reset, 1'b0);
      end
      reset = 1'b1; msip = 1'b1;
      #1 reset = 1'b0;
      #1;
      check("lit_release_msip_hi", core_reset, 1'b0);
      step();
      check("lit_release_edge_pulse", core_reset, 1'b1);

      for (int c = 0; c < 3000; c++) begin
         step();
         bus.icache_req_valid = 1'($urandom_range(0, 1));
         bus.icache_req_addr  = 30'($urandom);
         bus.icache_req_tag   = ITW'($urandom);
         bus.icache_rsp_ready = 1'($urandom_range(0, 1));
         bus.imem_a_ready     = 1'($urandom_range(0, 1));
         bus.imem_d_valid     = 1'($urandom_range(0, 1));
         bus.imem_d_opcode    = 3'($urandom);
         bus.imem_d_size      = 4'($urandom);
         bus.imem_d_source    = SW'($urandom);
         bus.imem_d_data      = $urandom;
         bus.dcache_req_valid = N'($urandom);
         bus.dcache_req_rw    = N'($urandom);
         bus.dcache_req_tag   = DTW'($urandom);
         bus.dcache_rsp_ready = 1'($urandom_range(0, 1));
         bus.dmem_a_ready     = N'($urandom);
         bus.dmem_d_valid     = N'($urandom);
         for (int i = 0; i < N; i++) begin
            a = 30'($urandom);
            if ($urandom_range(0, 3) == 0) a[29:26] = 4'hC;
            bus.dcache_req_addr[i*30 +: 30]   = a;
            bus.dcache_req_byteen[i*4 +: 4]   = 4'($urandom);
            bus.dcache_req_data[i*32 +: 32]   = $urandom;
            bus.dmem_d_opcode[i*3 +: 3]       = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom);
            bus.dmem_d_size[i*4 +: 4]         = 4'($urandom);
            bus.dmem_d_source[i*SW +: SW]     = SW'($urandom);
            bus.dmem_d_data[i*32 +: 32]       = $urandom;
         end
         busy = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) msip = ~msip;
      end

      step();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vx_tl_mem_adapter.md
# vx_tl_mem_adapter

Combinational bridge between the Vortex core pipeline's instruction/data cache request/response interfaces (`VX_icache_req_if`, `VX_icache_rsp_if`, `VX_dcache_req_if`, `VX_dcache_rsp_if`) and TileLink-style A/D channels: one imem port and `NUM_LANES` dmem ports. It also generates a fixed-length core reset pulse on a software-interrupt (msip) rising edge, and produces the tile status outputs. It sits in the Vortex tile wrapper, between the pipeline and the Chisel tile's TileLink nodes.

## Interface
Parameters:
- `NUM_LANES`, 4, dmem lanes (threads)
- `ITAG_W`, 8, icache core tag width
- `DTAG_W`, 8, dcache core tag width; `ITAG_W` and `DTAG_W` are both ≤ `SRC_W`
- `SRC_W`, 10, TileLink source width
- `RST_PULSE`, 6, msip reset pulse length in cycles

Ports (vectors are lane-packed, lane 0 in the LSBs):
- `clock` in 1: clock
- `reset` in 1: asynchronous, active-high
- `interrupts_msip` in 1: software interrupt
- `core_reset` out 1: reset to the pipeline
- `busy` in 1: pipeline busy
- `cease` out 1; `wfi` out 1
- `icache_req_valid/addr/tag/ready`: in 1 / in 30 (word address) / in `ITAG_W` / out 1
- `icache_rsp_valid/data/tag/ready`: out 1 / out 32 / out `ITAG_W` / in 1
- `dcache_req_valid/rw/byteen/addr/data/tag/ready`: in N / in N / in 4N / in 30N / in 32N / in `DTAG_W` / out N
- `dcache_rsp_valid/tmask/data/tag/ready`: out 1 / out N / out 32N / out `DTAG_W` / in 1
- `imem_a_valid/opcode/size/source/address/mask/data/ready`: out 1/3/4/`SRC_W`/32/4/32, in 1
- `imem_d_valid/opcode/size/source/data/ready`: in 1/3/4/`SRC_W`/32, out 1
- `dmem_a_*`, `dmem_d_*`: same fields as imem, each replicated per lane (N, 3N, 4N, `SRC_W`·N, 32N, …)

## Operation
- imem A channel:
  - `a_valid` = `icache_req_valid`; `address` = {addr, 2'b00}; `source` = zero-extended tag.
  - `opcode` = 4 (Get); `size` = 2; `mask` = 4'hF; `data` = 0.
  - `icache_req_ready` = `imem_a_ready`.
- imem D channel:
  - `icache_rsp_valid` = `d_valid`; `data` = `d_data`; `tag` = `d_source[ITAG_W-1:0]`.
  - `imem_d_ready` = `icache_rsp_ready`.
- dmem A channel, per lane i:
  - `a_valid[i]` = `req_valid[i]`; `address` = {addr[i], 2'b00}; `source` = zero-extended shared `dcache_req_tag`.
  - `data` = `data[i]`; `mask` = `byteen[i]`.
  - `opcode` = `rw[i]` ? 0 (PutFull; partial masks are also sent as PutFull) : 4 (Get); `size` = 2.
  - `dcache_req_ready[i]` = `dmem_a_ready[i]`.
- dmem D channel:
  - Per-lane response: `lv[i]` = `d_valid[i] && d_opcode[i] != 0`. AccessAck beats are dropped but still consumed.
  - `tmask` = lv; `dcache_rsp_valid` = |lv; `data` = concatenation of lane `d_data`.
  - `tag` = `d_source[DTAG_W-1:0]` of the highest-index lane with `d_valid` set (unfiltered); 0 if no lane is valid.
  - Every `dmem_d_ready[i]` = `dcache_rsp_ready`.
- Status: `cease` = ~`busy`; `wfi` = 0.
- Interrupt reset:
  - Register `msip_d` samples `interrupts_msip` every cycle.
  - Counter `cnt`: loads `RST_PULSE` on a rising edge (`!msip_d && msip`); otherwise decrements, saturating at 0.
  - `core_reset` = `reset` | (`cnt` != 0).
- Simulation only: display a store to any address whose bits [31:28] equal 4'hC, at `dcache_req` valid & ready & rw. The message includes the lane, the address and the data.

## Timing
- All data paths are purely combinational; no added latency.
- Valid/ready pass straight through; the block holds no buffering and has no backpressure of its own.
- Async reset: `msip_d` = 0 and `cnt` = 0.
  - `core_reset` is 1 while `reset` is asserted, then 0.
  - If msip is high at reset release, the first clock edge detects a rising edge.
- Edge sampled at edge k → `core_reset` is high for exactly `RST_PULSE` cycles, from after edge k to after edge k+`RST_PULSE`.
- A new rising edge during a pulse reloads `cnt` to `RST_PULSE` (extends the pulse).
- Holding msip high produces a single pulse only.
- Reset asserted mid-pulse clears `cnt` immediately.
- Response tag selection is by valid only. Lanes are expected to carry the same source, so lane mismatch is not checked.

## Test plan
- Reset then idle:
  - `core_reset` = 1 during reset, then 0.
  - imem `opcode` = 4, `size` = 2, `mask` = F, `data` = 0; `wfi` = 0; `busy` = 0 → `cease` = 1.
- icache req with addr = 0x0000_0400, tag = 0x15:
  - imem `address` = 0x0000_1000, `source` = 0x015.
  - `imem_a_ready` toggling is mirrored on `icache_req_ready`.
  - D response with source 0x015 and data 0xDEADBEEF → `icache_rsp` tag 0x15, data 0xDEADBEEF.
- dcache store on lanes 0 and 2 (rw = 1, byteen = 0x3 on lane 2), tag 0x07 → `a_valid` = 0101b, `opcode` = 0 on both lanes, lane 2 `mask` = 0x3, all lanes `source` = 0x007.
- D beats on lanes 1 (AccessAckData, opcode 1, source 0x09) and 3 (AccessAck, opcode 0, source 0x0A):
  - `tmask` = 0010b, `rsp_valid` = 1, `tag` = 0x0A (highest valid lane).
  - With `dcache_rsp_ready` = 0, all `d_ready` = 0.
- msip 0→1, held for 20 cycles:
  - `core_reset` is high for exactly 6 cycles starting the cycle after the sampled edge; no further pulse while msip stays high.
  - Toggling msip at pulse cycle 3 extends the pulse to 6 cycles from the new edge.
- Assert `reset` at pulse cycle 2 → `cnt` = 0 immediately; after release `core_reset` = 0.
